// File: rtl/mem_ir_regbank_pkg.sv
// Shared constants for the memory / instruction register / register bank slice.
// Holds memory geometry, stack-pointer reset value and IR field positions.
package mem_ir_regbank_pkg;

    localparam int MEM_BYTES = 256;
    localparam int MEM_AW    = 8;

    localparam int          SP_INDEX = 29;
    localparam logic [31:0] SP_RESET = 32'd227;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Byte address of lane `off` of a word based at `base`; wraps at 256.
    function automatic logic [MEM_AW-1:0] lane_addr(input logic [MEM_AW-1:0] base,
                                                    input logic [1:0]        off);
        return base + MEM_AW'(off);
    endfunction

endpackage

// File: rtl/regbank32.sv
// 32 x 32-bit register file: combinational reads, one write port, r0 hard-wired to zero.
// Reads return pre-edge contents; sync reset loads the stack pointer, clears the rest.
module regbank32
    import mem_ir_regbank_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [4:0]  wreg,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
            end
        end else if (wr && (wreg != 5'd0)) begin
            regs[wreg] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mem_ir_regbank.sv
// Byte memory with registered word reads feeding an instruction register and register bank.
// mem_rdata lags mem_addr by one cycle; no flow control, every enable acts on its edge.
module mem_ir_regbank
    import mem_ir_regbank_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        ir_wr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm,
    input  logic        rb_wr,
    input  logic [4:0]  rb_wreg,
    input  logic [31:0] rb_wdata,
    output logic [31:0] rb_rdata1,
    output logic [31:0] rb_rdata2
);

    logic [7:0]        mem [MEM_BYTES];
    logic [MEM_AW-1:0] base;
    logic [31:0]       ir;
    logic              unused_addr_bits;

    assign base             = mem_addr[MEM_AW-1:0];
    assign unused_addr_bits = ^mem_addr[31:MEM_AW];

    // Memory ignores reset; the read samples pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                mem[lane_addr(base, 2'(i))] <= mem_wdata[8*i +: 8];
            end
        end
        mem_rdata <= {mem[lane_addr(base, 2'd3)], mem[lane_addr(base, 2'd2)],
                      mem[lane_addr(base, 2'd1)], mem[lane_addr(base, 2'd0)]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= 32'd0;
        end else if (ir_wr) begin
            ir <= mem_rdata;
        end
    end

    assign opcode = ir[OP_HI:OP_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign imm    = ir[IMM_HI:IMM_LO];

    regbank32 u_regbank (
        .clk    (clk),
        .reset  (reset),
        .wr     (rb_wr),
        .wreg   (rb_wreg),
        .wdata  (rb_wdata),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rb_rdata1),
        .rdata2 (rb_rdata2)
    );

endmodule

// File: tb/tb_mem_ir_regbank.sv
// Directed plus random bench for mem_ir_regbank against a byte/word reference model.
module tb_mem_ir_regbank;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ir_wr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        rb_wr;
    logic [4:0]  rb_wreg;
    logic [31:0] rb_wdata;
    logic [31:0] rb_rdata1;
    logic [31:0] rb_rdata2;

    mem_ir_regbank dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ir_wr     (ir_wr),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .rb_wr     (rb_wr),
        .rb_wreg   (rb_wreg),
        .rb_wdata  (rb_wdata),
        .rb_rdata1 (rb_rdata1),
        .rb_rdata2 (rb_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mem_m  [256];
    logic [31:0] regs_m [32];
    logic [31:0] ir_m;
    logic [31:0] rdata_m;
    bit          ready;
    bit          mem_known;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] a);
        return {mem_m[8'(a + 8'd3)], mem_m[8'(a + 8'd2)], mem_m[8'(a + 8'd1)], mem_m[a]};
    endfunction

    // Apply inputs and check the combinational register reads before the edge.
    task automatic drive(input bit r, input bit mw, input logic [31:0] ma, input logic [31:0] md,
                         input bit iw, input bit rw, input logic [4:0] wreg, input logic [31:0] wd);
        reset     = r;
        mem_wr    = mw;
        mem_addr  = ma;
        mem_wdata = md;
        ir_wr     = iw;
        rb_wr     = rw;
        rb_wreg   = wreg;
        rb_wdata  = wd;
        #1;
        if (ready) begin
            chk("rb_rdata1_pre", rb_rdata1, regs_m[ir_m[25:21]]);
            chk("rb_rdata2_pre", rb_rdata2, regs_m[ir_m[20:16]]);
        end
    endtask

    // Advance the model by one edge, clock the DUT, check registered outputs.
    task automatic edge_chk();
        logic [31:0] nrd;
        nrd = word_at(mem_addr[7:0]);
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) mem_m[8'(mem_addr[7:0] + 8'(i))] = mem_wdata[8*i +: 8];
        end
        if (reset) begin
            ir_m = 32'd0;
            for (int i = 0; i < 32; i++) regs_m[i] = (i == 29) ? 32'd227 : 32'd0;
        end else begin
            if (ir_wr) ir_m = rdata_m;
            if (rb_wr && rb_wreg != 5'd0) regs_m[rb_wreg] = rb_wdata;
        end
        rdata_m = nrd;
        @(posedge clk);
        #1;
        if (mem_known) chk("mem_rdata", mem_rdata, rdata_m);
        chk("opcode", 32'(opcode), 32'(ir_m[31:26]));
        chk("rs", 32'(rs), 32'(ir_m[25:21]));
        chk("rt", 32'(rt), 32'(ir_m[20:16]));
        chk("imm", 32'(imm), 32'(ir_m[15:0]));
    endtask

    task automatic step(input bit r, input bit mw, input logic [31:0] ma, input logic [31:0] md,
                        input bit iw, input bit rw, input logic [4:0] wreg, input logic [31:0] wd);
        drive(r, mw, ma, md, iw, rw, wreg, wd);
        edge_chk();
    endtask

    task automatic load_ir(input logic [31:0] w);
        step(0, 1, 32'd200, w, 0, 0, 5'd0, 32'd0);
        step(0, 0, 32'd200, 32'd0, 0, 0, 5'd0, 32'd0);
        step(0, 0, 32'd200, 32'd0, 1, 0, 5'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        n_checks  = 0;
        n_fail    = 0;
        ready     = 0;
        mem_known = 0;
        ir_m      = 32'd0;
        rdata_m   = 32'd0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'd0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;

        // Reset state
        step(1, 0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        ready = 1;
        chk("reset_opcode", 32'(opcode), 32'd0);
        chk("reset_imm", 32'(imm), 32'd0);
        chk("reset_rdata1", rb_rdata1, 32'd0);

        // Fill memory so every byte is known to the model
        for (int w = 0; w < 64; w++) step(0, 1, 32'(4 * w), $urandom, 0, 0, 5'd0, 32'd0);
        mem_known = 1;

        // Aligned word write/read
        step(0, 1, 32'd8, 32'h11223344, 0, 0, 5'd0, 32'd0);
        step(0, 0, 32'd8, 32'd0, 0, 0, 5'd0, 32'd0);
        chk("word_at_8", mem_rdata, 32'h11223344);
        chk("byte_at_8", 32'(mem_rdata[7:0]), 32'h44);

        // Wrap-around word at 254; upper address bits ignored
        step(0, 1, 32'hFFFF_00FE, 32'hAABBCCDD, 0, 0, 5'd0, 32'd0);
        step(0, 0, 32'd254, 32'd0, 0, 0, 5'd0, 32'd0);
        chk("word_at_254", mem_rdata, 32'hAABBCCDD);
        step(0, 0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        chk("byte_at_0", 32'(mem_rdata[7:0]), 32'hBB);
        chk("byte_at_1", 32'(mem_rdata[15:8]), 32'hAA);

        // Read during write returns old contents
        old = word_at(8'd16);
        step(0, 1, 32'd16, 32'hCAFEF00D, 0, 0, 5'd0, 32'd0);
        chk("rdw_old", mem_rdata, old);
        step(0, 0, 32'd16, 32'd0, 0, 0, 5'd0, 32'd0);
        chk("rdw_new", mem_rdata, 32'hCAFEF00D);

        // IR load and hold
        load_ir(32'h8D2A0010);
        chk("ir_opcode", 32'(opcode), 32'h23);
        chk("ir_rs", 32'(rs), 32'd9);
        chk("ir_rt", 32'(rt), 32'd10);
        chk("ir_imm", 32'(imm), 32'h0010);
        step(0, 1, 32'd36, 32'h12345678, 0, 0, 5'd0, 32'd0);
        step(0, 0, 32'd36, 32'd0, 0, 0, 5'd0, 32'd0);
        step(0, 0, 32'd36, 32'd0, 0, 0, 5'd0, 32'd0);
        chk("hold_rdata", mem_rdata, 32'h12345678);
        chk("hold_opcode", 32'(opcode), 32'h23);
        chk("hold_imm", 32'(imm), 32'h0010);

        // Reset beats ir_wr and rb_wr; memory write still lands
        step(1, 1, 32'd40, 32'h0BADCAFE, 1, 1, 5'd29, 32'hFFFFFFFF);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_rs", 32'(rs), 32'd0);
        step(0, 0, 32'd40, 32'd0, 0, 0, 5'd0, 32'd0);
        chk("rst_memwrite", mem_rdata, 32'h0BADCAFE);
        for (int k = 0; k < 16; k++) begin
            load_ir({6'd0, 5'(2 * k), 5'(2 * k + 1), 16'd0});
            chk("rst_reg_even", rb_rdata1, 32'd0);
            chk("rst_reg_odd", rb_rdata2, (2 * k + 1 == 29) ? 32'd227 : 32'd0);
        end

        // Register write: old value before the edge, new after
        load_ir(32'h00A60000);
        drive(0, 0, 32'd0, 32'd0, 0, 1, 5'd5, 32'hDEADBEEF);
        chk("r5_before", rb_rdata1, 32'd0);
        edge_chk();
        chk("r5_after", rb_rdata1, 32'hDEADBEEF);

        // Register 0 ignores writes; reset wins over a write to r29
        load_ir(32'h001D0000);
        step(0, 0, 32'd0, 32'd0, 0, 1, 5'd0, 32'hFFFFFFFF);
        chk("r0_zero", rb_rdata1, 32'd0);
        chk("r29_sp", rb_rdata2, 32'd227);
        step(0, 0, 32'd0, 32'd0, 0, 1, 5'd29, 32'h12345678);
        chk("r29_write", rb_rdata2, 32'h12345678);
        step(1, 0, 32'd0, 32'd0, 0, 1, 5'd29, 32'h87654321);
        load_ir(32'h00BD0000);
        chk("r29_rst_wins", rb_rdata2, 32'd227);
        chk("r5_cleared", rb_rdata1, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ir_regbank.md
MEM_IR_REGBANK -- requirements
Module: mem_ir_regbank

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port mem_addr, input, 32 bits: memory byte address; only bits [7:0] are used.
REQ-005 SHALL have port mem_wr, input, 1 bit: memory write enable.
REQ-006 SHALL have port mem_wdata, input, 32 bits: memory write word.
REQ-007 SHALL have port mem_rdata, output, 32 bits: memory read word.
REQ-008 SHALL have port ir_wr, input, 1 bit: instruction register load enable.
REQ-009 SHALL have port opcode, output, 6 bits: IR[31:26].
REQ-010 SHALL have port rs, output, 5 bits: IR[25:21].
REQ-011 SHALL have port rt, output, 5 bits: IR[20:16].
REQ-012 SHALL have port imm, output, 16 bits: IR[15:0].
REQ-013 SHALL have port rb_wr, input, 1 bit: register bank write enable.
REQ-014 SHALL have port rb_wreg, input, 5 bits: register bank write index.
REQ-015 SHALL have port rb_wdata, input, 32 bits: register bank write data.
REQ-016 SHALL have port rb_rdata1, output, 32 bits: value of register rs.
REQ-017 SHALL have port rb_rdata2, output, 32 bits: value of register rt.

Function
REQ-018 Memory SHALL be 256 bytes; a word at address a SHALL span bytes a..a+3 mod 256 (wrap-around), with byte a in bits [7:0] (little-endian).
REQ-019 Memory read SHALL be registered: mem_rdata SHALL show the word at the mem_addr sampled at the previous rising edge (1-cycle latency).
REQ-020 On a rising edge with mem_wr=1, all 4 bytes at mem_addr SHALL be written; a read in the same cycle SHALL return the old contents.
REQ-021 With ir_wr=1 on a rising edge, the IR SHALL load mem_rdata; with ir_wr=0 it SHALL hold its value.
REQ-022 opcode/rs/rt/imm SHALL be combinational slices of the IR.
REQ-023 Register bank: 32 x 32-bit registers; read addresses SHALL be rs and rt taken internally from the IR; reads SHALL be combinational.
REQ-024 With rb_wr=1 on a rising edge, register rb_wreg SHALL take rb_wdata; a write to index 0 SHALL be ignored, and register 0 SHALL always read 0.
REQ-025 Read-during-write to the same register SHALL return the old value until the edge; the new value SHALL appear after the edge.
REQ-026 When reset and a write enable are both 1 on an edge, reset SHALL win for the IR and the register bank; memory writes SHALL still occur.

Reset
REQ-027 On a reset edge, the IR SHALL clear to 0, so opcode, rs, rt and imm are all 0.
REQ-028 On a reset edge, register 29 (stack pointer) SHALL be set to 227; all other registers SHALL be set to 0.
REQ-029 Memory contents and the mem_rdata register SHALL NOT be affected by reset; memory SHALL power up all-zero unless loaded from an optional init file.

Structure
REQ-030 A shared package SHALL hold MEM_BYTES=256, SP_INDEX=29, SP_RESET=227, and the IR field bit positions.
REQ-031 The register bank SHALL be one sub-module, regbank32; the memory and the IR SHALL be inline.

Verification
REQ-032 Test: write 0x11223344 to address 8, then read address 8 -> mem_rdata=0x11223344 one cycle after the read address; byte address 8 holds 0x44.
REQ-033 Test: write 0xAABBCCDD at address 254, then read address 254 -> 0xAABBCCDD, with bytes 0 and 1 holding 0xBB and 0xAA (wrap-around).
REQ-034 Test: set mem_rdata=0x8D2A0010 and pulse ir_wr -> opcode=0x23, rs=9, rt=10, imm=0x0010; ir_wr=0 with a new mem_rdata -> fields unchanged.
REQ-035 Test: apply reset -> IR fields=0; read reg 29 -> 227; all other regs -> 0.
REQ-036 Test: rb_wr with rb_wreg=5, rb_wdata=0xDEADBEEF, and rs=5 -> rb_rdata1=0 before the edge and 0xDEADBEEF after it.
REQ-037 Test: rb_wr with rb_wreg=0, rb_wdata=0xFFFFFFFF, and rs=0 -> rb_rdata1=0; reset and rb_wr both asserted for reg 29 -> reg 29=227.
